// File: rtl/bsg_burst_beat_tracker_pkg.sv
// Shared types and helpers for the burst beat tracker.
// Holds the counter-width helper and the tracker status struct.
package bsg_burst_beat_tracker_pkg;

    localparam int status_cnt_width_gp = 16;

    // A zero-width counter is illegal, so a single-index range still gets one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                           v;
        logic                           done;
        logic                           lock;
        logic [status_cnt_width_gp-1:0] cnt;
    } tracker_status_s;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/bsg_burst_hdr_slot.sv
// Single-entry header buffer with ready/valid enqueue and yumi dequeue.
// Enqueue is only allowed when empty, which gives one bubble cycle between bursts.
module bsg_burst_hdr_slot
    import bsg_burst_beat_tracker_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    slot_state_e          state_r, state_n;
    logic [width_p-1:0]   data_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    // Header storage needs no reset; it is only observed while the slot is full.
    always_ff @(posedge clk_i) begin
        if (v_i && ready_o) begin
            data_r <= data_i;
        end
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_r)
            SLOT_EMPTY: begin
                ready_o = 1'b1;
                if (v_i) begin
                    state_n = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_n = SLOT_EMPTY;
                end
            end
            default: state_n = SLOT_EMPTY;
        endcase
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_burst_beat_tracker.sv
// Tracks one multi-beat burst: buffers its header and walks a modular beat index to the last beat.
// Define BSG_BURST_BEAT_TRACKER_ASSERT_EN to enable simulation-only protocol checks.
module bsg_burst_beat_tracker
    import bsg_burst_beat_tracker_pkg::*;
#(
    parameter int header_width_p = 64,
    parameter int max_val_p      = 7,
    parameter int reset_val_p    = 0,
    localparam int cnt_width_lp  = safe_clog2(max_val_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [header_width_p-1:0] header_i,
    input  logic [cnt_width_lp-1:0]   first_cnt_i,
    input  logic [cnt_width_lp-1:0]   last_cnt_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [header_width_p-1:0] header_o,
    output logic                      v_o,
    output logic [cnt_width_lp-1:0]   cnt_o,
    output logic [cnt_width_lp-1:0]   last_cnt_o,
    input  logic                      beat_i,
    output logic                      done_o,
    output logic                      lock_o
);

    logic                    accept;
    logic                    slot_v;
    logic                    yumi;
    logic                    match;
    logic [cnt_width_lp-1:0] cnt_r;
    logic [cnt_width_lp-1:0] last_r;
    tracker_status_s         status;

    assign accept = v_i & ready_o;
    assign yumi   = beat_i & status.done;

    bsg_burst_hdr_slot #(
        .width_p (header_width_p)
    ) hdr_slot (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (header_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (header_o),
        .v_o     (slot_v),
        .yumi_i  (yumi)
    );

    // Loading a new burst wins over advancing; beats are ignored while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= cnt_width_lp'(reset_val_p);
        end else if (accept) begin
            cnt_r <= first_cnt_i;
        end else if (beat_i && slot_v) begin
            cnt_r <= (cnt_r == cnt_width_lp'(max_val_p)) ? '0 : cnt_r + cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r <= '0;
        end else if (accept) begin
            last_r <= last_cnt_i;
        end
    end

    assign last_cnt_o = accept ? last_cnt_i : last_r;
    assign match      = (cnt_r == last_cnt_o);

    assign status = '{
        v:    slot_v,
        done: slot_v & match,
        lock: slot_v & ~match,
        cnt:  status_cnt_width_gp'(cnt_r)
    };

    assign v_o    = status.v;
    assign done_o = status.done;
    assign lock_o = status.lock;
    assign cnt_o  = cnt_width_lp'(status.cnt);

`ifdef BSG_BURST_BEAT_TRACKER_ASSERT_EN
    logic [header_width_p-1:0] header_prev_r;
    logic                      hold_prev_r;

    // An offer held against a full buffer must keep its header stable across cycles.
    always_ff @(posedge clk_i) begin
        header_prev_r <= header_i;
        hold_prev_r   <= v_i & ~ready_o & ~reset_i;
        if (!reset_i) begin
            assert (!(beat_i && !v_o))
                else $error("bsg_burst_beat_tracker: beat_i asserted with no active burst");
            if (accept) begin
                assert ((int'(first_cnt_i) <= max_val_p) && (int'(last_cnt_i) <= max_val_p))
                    else $error("bsg_burst_beat_tracker: burst index exceeds max_val_p");
            end
            if (hold_prev_r && v_i && !ready_o) begin
                assert (header_i == header_prev_r)
                    else $error("bsg_burst_beat_tracker: header_i changed while stalled");
            end
        end
    end
`else
    // Protocol checks compiled out.
`endif

endmodule

// File: tb/tb_bsg_burst_beat_tracker.sv
// Scoreboard bench for bsg_burst_beat_tracker: stimulus pushes expected beats, a monitor pops them.
// Expected beats come from burst length arithmetic, not from the counter's structure.
module tb_bsg_burst_beat_tracker;

    localparam int hw = 64;
    localparam int mv = 7;
    localparam int nidx = mv + 1;

    typedef struct {
        logic [hw-1:0] header;
        logic [2:0]    cnt;
        logic [2:0]    last;
        bit            done;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [hw-1:0] header_i;
    logic [2:0]    first_cnt_i;
    logic [2:0]    last_cnt_i;
    logic          v_i;
    logic          ready_o;
    logic [hw-1:0] header_o;
    logic          v_o;
    logic [2:0]    cnt_o;
    logic [2:0]    last_cnt_o;
    logic          beat_i;
    logic          done_o;
    logic          lock_o;

    beat_t      exp_q[$];
    beat_t      e;
    bit         exp_full = 1'b0;
    bit         checking_en = 1'b0;
    logic [2:0] cur_last = '0;
    int         vectors = 0;
    int         miscompares = 0;

    bsg_burst_beat_tracker #(
        .header_width_p (hw),
        .max_val_p      (mv),
        .reset_val_p    (0)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .header_i    (header_i),
        .first_cnt_i (first_cnt_i),
        .last_cnt_i  (last_cnt_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .header_o    (header_o),
        .v_o         (v_o),
        .cnt_o       (cnt_o),
        .last_cnt_o  (last_cnt_o),
        .beat_i      (beat_i),
        .done_o      (done_o),
        .lock_o      (lock_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [hw-1:0] act, input logic [hw-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the state update.
    always @(negedge clk_i) begin
        if (checking_en) begin
            checkOutput("ready_o", ready_o, !exp_full);
            checkOutput("v_o", v_o, exp_full);
            if (v_i && !exp_full) begin
                checkOutput("last_bypass", last_cnt_o, cur_last);
            end
            if (v_o) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL beat_queued: got active beat, expected none at %0t", $time);
                end else begin
                    e = exp_q[0];
                    checkOutput("cnt_o", cnt_o, e.cnt);
                    checkOutput("done_o", done_o, e.done);
                    checkOutput("lock_o", lock_o, !e.done);
                    checkOutput("header_o", header_o, e.header);
                    checkOutput("last_cnt_o", last_cnt_o, e.last);
                    if (beat_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                checkOutput("done_idle", done_o, 1'b0);
                checkOutput("lock_idle", lock_o, 1'b0);
            end
        end
    end

    // Offers one burst, then consumes all its beats with optional stalls during which a rival offer is made.
    task automatic applyStimulus(input logic [2:0] first, input logic [2:0] last, input logic [hw-1:0] hdr,
                                 input int stall_at, input int stall_len, input bit rnd);
        int            len;
        int            stalls;
        logic [hw-1:0] rival;
        len   = ((int'(last) - int'(first) + nidx) % nidx) + 1;
        rival = {$urandom, $urandom};
        v_i = 1'b1;
        header_i = hdr;
        first_cnt_i = first;
        last_cnt_i = last;
        beat_i = 1'b0;
        cur_last = last;
        @(posedge clk_i); #1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{header: hdr, cnt: 3'((int'(first) + i) % nidx), last: last, done: (i == len - 1)});
        end
        exp_full = 1'b1;
        v_i = 1'b0;
        header_i = rival;
        first_cnt_i = 3'($urandom_range(0, mv));
        last_cnt_i = 3'($urandom_range(0, mv));
        for (int b = 0; b < len; b++) begin
            if (b == stall_at) stalls = stall_len;
            else if (rnd && ($urandom_range(0, 3) == 0)) stalls = $urandom_range(1, 3);
            else stalls = 0;
            repeat (stalls) begin
                beat_i = 1'b0;
                v_i = 1'($urandom_range(0, 1));
                @(posedge clk_i); #1;
            end
            beat_i = 1'b1;
            v_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk_i); #1;
        end
        beat_i = 1'b0;
        v_i = 1'b0;
        exp_full = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        v_i = 1'b0;
        beat_i = 1'b0;
        header_i = '0;
        first_cnt_i = '0;
        last_cnt_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_ready", ready_o, 1'b1);
        checkOutput("reset_v", v_o, 1'b0);
        checkOutput("reset_cnt", cnt_o, 3'd0);
        checkOutput("reset_last", last_cnt_o, 3'd0);
        checkOutput("reset_done", done_o, 1'b0);
        checkOutput("reset_lock", lock_o, 1'b0);
        reset_i = 1'b0;
        checking_en = 1'b1;

        applyStimulus(3'd2, 3'd5, 64'hABCD, -1, 0, 1'b0);
        applyStimulus(3'd3, 3'd3, 64'h1111_2222_3333_4444, -1, 0, 1'b0);
        applyStimulus(3'd6, 3'd1, 64'h6161, -1, 0, 1'b0);
        applyStimulus(3'd2, 3'd5, 64'hDEAD_BEEF, 1, 4, 1'b0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(3'($urandom_range(0, mv)), 3'($urandom_range(0, mv)),
                          {$urandom, $urandom}, -1, 0, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk_i); #1;
            end
        end

        // Reset in the middle of a 2..5 burst, while cnt_o shows 4.
        v_i = 1'b1;
        header_i = 64'h5A5A;
        first_cnt_i = 3'd2;
        last_cnt_i = 3'd5;
        cur_last = 3'd5;
        @(posedge clk_i); #1;
        for (int i = 2; i <= 4; i++) begin
            exp_q.push_back('{header: 64'h5A5A, cnt: 3'(i), last: 3'd5, done: 1'b0});
        end
        exp_full = 1'b1;
        v_i = 1'b0;
        beat_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        beat_i = 1'b0;
        @(posedge clk_i); #1;
        checking_en = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("midreset_v", v_o, 1'b0);
        checkOutput("midreset_ready", ready_o, 1'b1);
        checkOutput("midreset_cnt", cnt_o, 3'd0);
        checkOutput("midreset_last", last_cnt_o, 3'd0);
        checkOutput("midreset_done", done_o, 1'b0);
        checkOutput("midreset_lock", lock_o, 1'b0);
        exp_q.delete();
        exp_full = 1'b0;
        reset_i = 1'b0;
        checking_en = 1'b1;

        applyStimulus(3'd7, 3'd0, 64'h7070, -1, 0, 1'b0);
        @(posedge clk_i); #1;
        checking_en = 1'b0;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
